// File: rtl/laplacian_core.sv
// 3x3 Laplacian edge-detection engine producing a saturated signed result per window.
// Latency: 3 enabled edges from window capture to data_o, with sonuc_done raised on the third.
// Backpressure: none; en_i gates every stage, so lowering it freezes the pipeline and clears done.
// Optional feature: define LAPLACIAN_DIAG_EN for the 8-neighbour kernel (default is 4-neighbour).
module laplacian_core #(
  parameter int DW = 8,
  parameter int OW = 9
) (
  input  logic          clk_i,
  input  logic          rst_i,
  input  logic [DW-1:0] data_i_0,
  input  logic [DW-1:0] data_i_1,
  input  logic [DW-1:0] data_i_2,
  input  logic [DW-1:0] data_i_3,
  input  logic [DW-1:0] data_i_4,
  input  logic [DW-1:0] data_i_5,
  input  logic [DW-1:0] data_i_6,
  input  logic [DW-1:0] data_i_7,
  input  logic [DW-1:0] data_i_8,
  input  logic          en_i,
  output logic [OW-1:0] data_o,
  output logic          sonuc_done
);

  // Neighbour sum holds up to eight full-scale pixels, so three extra bits.
  localparam int NW = DW + 3;
`ifdef LAPLACIAN_DIAG_EN
  localparam int KW = DW + 5;
`else
  localparam int KW = DW + 4;
`endif
  // Intermediate must hold the unclamped kernel and the clamp bounds.
  localparam int IW = (KW > OW + 1) ? KW : OW + 1;
  localparam logic signed [IW-1:0] SAT_MAX = IW'((1 << (OW - 1)) - 1);
  localparam logic signed [IW-1:0] SAT_MIN = IW'(-(1 << (OW - 1)));

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FILL1 = 2'd1,
    FILL2 = 2'd2,
    DONE  = 2'd3
  } state_t;

  state_t state_q, state_d;

  logic [DW-1:0] pix_d [9];
  logic [DW-1:0] pix_q [9];
  logic [NW-1:0] ctr_d, ctr_q;
  logic [NW-1:0] nsum_d, nsum_q;
  logic signed [IW-1:0] diff;
  logic signed [IW-1:0] sat;

  assign pix_d[0] = data_i_0;
  assign pix_d[1] = data_i_1;
  assign pix_d[2] = data_i_2;
  assign pix_d[3] = data_i_3;
  assign pix_d[4] = data_i_4;
  assign pix_d[5] = data_i_5;
  assign pix_d[6] = data_i_6;
  assign pix_d[7] = data_i_7;
  assign pix_d[8] = data_i_8;

  // Done-count state register; the state encoding is the enabled-edge count.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Count consecutive enabled edges up to three; any idle edge restarts the count.
  always_comb begin
    state_d = IDLE;
    if (en_i) begin
      case (state_q)
        IDLE:    state_d = FILL1;
        FILL1:   state_d = FILL2;
        FILL2:   state_d = DONE;
        default: state_d = DONE;
      endcase
    end
  end

  // Result is valid only once three enabled edges have flushed the pipeline.
  always_comb begin
    sonuc_done = (state_q == DONE);
  end

  // S1: capture the whole window on every enabled edge.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      for (int i = 0; i < 9; i++) pix_q[i] <= '0;
    end else if (en_i) begin
      for (int i = 0; i < 9; i++) pix_q[i] <= pix_d[i];
    end
  end

  // Scaled centre and neighbour sum for the selected kernel, both unsigned.
  always_comb begin
`ifdef LAPLACIAN_DIAG_EN
    ctr_d  = NW'({pix_q[4], 3'b000});
    nsum_d = NW'(pix_q[0]) + NW'(pix_q[1]) + NW'(pix_q[2]) + NW'(pix_q[3])
           + NW'(pix_q[5]) + NW'(pix_q[6]) + NW'(pix_q[7]) + NW'(pix_q[8]);
`else
    ctr_d  = NW'({pix_q[4], 2'b00});
    nsum_d = NW'(pix_q[1]) + NW'(pix_q[3]) + NW'(pix_q[5]) + NW'(pix_q[7]);
`endif
  end

`ifndef LAPLACIAN_DIAG_EN
  // Corners are still captured in S1 but do not contribute to the 4-neighbour kernel.
  logic corner_unused;
  assign corner_unused = ^{pix_q[0], pix_q[2], pix_q[6], pix_q[8]};
`endif

  // S2: register the two kernel partial terms.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      ctr_q  <= '0;
      nsum_q <= '0;
    end else if (en_i) begin
      ctr_q  <= ctr_d;
      nsum_q <= nsum_d;
    end
  end

  // Subtract in widened signed arithmetic, then clamp into the output range.
  always_comb begin
    diff = $signed(IW'(ctr_q)) - $signed(IW'(nsum_q));
    sat  = diff;
    if (diff > SAT_MAX) begin
      sat = SAT_MAX;
    end else if (diff < SAT_MIN) begin
      sat = SAT_MIN;
    end
  end

  // S3: register the saturated result; it holds while en_i is low.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      data_o <= '0;
    end else if (en_i) begin
      data_o <= sat[OW-1:0];
    end
  end

endmodule

// File: tb/tb_laplacian_core.sv
module tb_laplacian_core;

  localparam int DW = 8;
  localparam int OW = 9;

`ifdef LAPLACIAN_DIAG_EN
  localparam logic [OW-1:0] EXP_MIXED = 9'h100;
  localparam logic [OW-1:0] EXP_SMALL = 9'h048;
`else
  localparam logic [OW-1:0] EXP_MIXED = 9'h064;
  localparam logic [OW-1:0] EXP_SMALL = 9'h024;
`endif
  localparam logic [OW-1:0] EXP_POS  = 9'h0FF;
  localparam logic [OW-1:0] EXP_NEG  = 9'h100;
  localparam logic [OW-1:0] EXP_ZERO = 9'h000;

  logic          clk_i = 1'b0;
  logic          rst_i;
  logic          en_i;
  logic [DW-1:0] pix [9];
  logic [OW-1:0] data_o;
  logic          sonuc_done;

  int errs   = 0;
  int checks = 0;

  // Reference model: results of windows seen on enabled edges, and the enabled-edge run length.
  int hist[$];
  int run = 0;

  always #5 clk_i = ~clk_i;

  laplacian_core #(.DW(DW), .OW(OW)) dut (
    .clk_i      (clk_i),
    .rst_i      (rst_i),
    .data_i_0   (pix[0]),
    .data_i_1   (pix[1]),
    .data_i_2   (pix[2]),
    .data_i_3   (pix[3]),
    .data_i_4   (pix[4]),
    .data_i_5   (pix[5]),
    .data_i_6   (pix[6]),
    .data_i_7   (pix[7]),
    .data_i_8   (pix[8]),
    .en_i       (en_i),
    .data_o     (data_o),
    .sonuc_done (sonuc_done)
  );

  // Laplacian of the current window from the kernel definition, clamped to the output range.
  function automatic int lap_ref();
    int l;
`ifdef LAPLACIAN_DIAG_EN
    l = 8 * int'(pix[4]);
    for (int i = 0; i < 9; i++) if (i != 4) l -= int'(pix[i]);
`else
    l = 4 * int'(pix[4]) - (int'(pix[1]) + int'(pix[3]) + int'(pix[5]) + int'(pix[7]));
`endif
    if (l > (1 << (OW - 1)) - 1) l = (1 << (OW - 1)) - 1;
    if (l < -(1 << (OW - 1))) l = -(1 << (OW - 1));
    return l;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One clock: update the model from what the DUT sampled, then compare #1 after the edge.
  task automatic tick();
    logic [OW-1:0] exp_d;
    @(posedge clk_i);
    if (rst_i) begin
      hist.delete();
      run = 0;
    end else if (en_i) begin
      hist.push_back(lap_ref());
      if (hist.size() > 3) void'(hist.pop_front());
      if (run < 3) run++;
    end else begin
      run = 0;
    end
    #1;
    exp_d = (hist.size() == 3) ? OW'(hist[0]) : '0;
    check("model_data_o", 32'(data_o), 32'(exp_d));
    check("model_done", 32'(sonuc_done), 32'(run == 3));
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic set_all(input logic [DW-1:0] v);
    for (int i = 0; i < 9; i++) pix[i] = v;
  endtask

  task automatic set_mixed();
    set_all(8'd255);
    pix[4] = 8'd50;
    pix[1] = 8'd10;
    pix[3] = 8'd20;
    pix[5] = 8'd30;
    pix[7] = 8'd40;
  endtask

  initial begin
    // Reset held two cycles with en_i high and a flat window present.
    rst_i = 1'b1;
    en_i  = 1'b1;
    set_all(8'd100);
    ticks(2);
    check("rst_data", 32'(data_o), 32'(EXP_ZERO));
    check("rst_done", 32'(sonuc_done), 32'd0);

    // Flat window: done on the third enabled edge after release, result zero.
    rst_i = 1'b0;
    ticks(2);
    check("flat_done_early", 32'(sonuc_done), 32'd0);
    tick();
    check("flat_done", 32'(sonuc_done), 32'd1);
    check("flat_data", 32'(data_o), 32'(EXP_ZERO));
    en_i = 1'b0;
    tick();
    check("flat_drop_done", 32'(sonuc_done), 32'd0);
    check("flat_drop_data", 32'(data_o), 32'(EXP_ZERO));

    // Mixed window.
    set_mixed();
    en_i = 1'b1;
    ticks(3);
    check("mixed_data", 32'(data_o), 32'(EXP_MIXED));
    check("mixed_done", 32'(sonuc_done), 32'd1);
    en_i = 1'b0;
    tick();
    check("mixed_hold", 32'(data_o), 32'(EXP_MIXED));

    // Positive saturation.
    set_all(8'd0);
    pix[4] = 8'd255;
    en_i = 1'b1;
    ticks(3);
    check("sat_pos", 32'(data_o), 32'(EXP_POS));
    en_i = 1'b0;
    tick();

    // Negative saturation.
    set_all(8'd255);
    pix[4] = 8'd0;
    en_i = 1'b1;
    ticks(3);
    check("sat_neg", 32'(data_o), 32'(EXP_NEG));
    en_i = 1'b0;
    tick();

    // Late-settling inputs: window arrives one cycle after en_i rises, sampled at cycle 36.
    set_all(8'd0);
    en_i = 1'b1;
    tick();
    set_mixed();
    ticks(35);
    check("late_data", 32'(data_o), 32'(EXP_MIXED));
    check("late_done", 32'(sonuc_done), 32'd1);
    en_i = 1'b0;
    tick();

    // Short pulse never raises done; then the small window run to completion.
    set_all(8'd1);
    pix[4] = 8'd10;
    en_i = 1'b1;
    ticks(2);
    check("pulse_done", 32'(sonuc_done), 32'd0);
    en_i = 1'b0;
    tick();
    check("pulse_off_done", 32'(sonuc_done), 32'd0);
    en_i = 1'b1;
    ticks(3);
    check("small_data", 32'(data_o), 32'(EXP_SMALL));
    en_i = 1'b0;
    tick();

    // Reset mid-computation aborts it.
    en_i = 1'b1;
    ticks(2);
    rst_i = 1'b1;
    tick();
    check("abort_done", 32'(sonuc_done), 32'd0);
    check("abort_data", 32'(data_o), 32'(EXP_ZERO));
    rst_i = 1'b0;
    en_i  = 1'b0;
    tick();

    // Randomized requests against the model: random windows, run lengths, mid-run changes, resets.
    for (int it = 0; it < 80; it++) begin
      for (int i = 0; i < 9; i++) begin
        case ($urandom_range(0, 3))
          0:       pix[i] = 8'd0;
          1:       pix[i] = 8'd255;
          default: pix[i] = 8'($urandom_range(0, 255));
        endcase
      end
      en_i = 1'b1;
      for (int c = 0; c < int'($urandom_range(1, 6)); c++) begin
        if ($urandom_range(0, 5) == 0) pix[$urandom_range(0, 8)] = 8'($urandom_range(0, 255));
        if ($urandom_range(0, 29) == 0) rst_i = 1'b1;
        tick();
        rst_i = 1'b0;
      end
      en_i = 1'b0;
      ticks($urandom_range(1, 2));
    end

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule

// File: doc/laplacian_core.md
# laplacian_core

Single-pixel 3x3 Laplacian edge-detection engine for the image-processing datapath. It receives one 3x3 window of 8-bit grey pixels, computes the second-derivative kernel response, saturates it to a signed 9-bit result, and signals completion. The frame sequencer feeds windows one at a time and collects results under an enable/done handshake.

## Interface
Parameters:
- `DW`, default 8: pixel width. Unsigned.
- `OW`, default 9: result width. Two's complement. Must satisfy `OW >= DW+1`.

Ports:
- `clk_i` in 1: clock. All logic is on the rising edge.
- `rst_i` in 1: reset. Synchronous and active-high.
- `data_i_0` … `data_i_8` in `DW` each: window pixels in row-major order. 0..2 are the top row, 3..5 the middle row, and 4 is the centre.
- `en_i` in 1: request. Hold it high until the result is taken.
- `data_o` out `OW`: signed, saturated Laplacian result.
- `sonuc_done` out 1: result valid.

## Operation
Default kernel (4-neighbour):
- L = 4·p4 − (p1 + p3 + p5 + p7).
- Compute in at least 12-bit signed intermediate arithmetic. No overflow is allowed before saturation.

Saturation:
- Clamp L to [−2^(OW−1), 2^(OW−1)−1], which is [−256, 255] for defaults.
- `data_o` = clamped value, two's complement.

Pipeline, 3 stages, advancing only on edges where `en_i`=1:
- S1 registers all nine pixels.
- S2 registers the scaled centre and the neighbour sum.
- S3 subtracts, saturates, and registers `data_o`.

Done counter, 2 bits:
- Cleared whenever `en_i`=0.
- Increments on each edge with `en_i`=1 until it reaches 3.
- `sonuc_done` = 1 when the count reaches 3.

While `en_i` stays high:
- The pipeline keeps re-sampling inputs every cycle.
- `data_o` tracks input changes with 3-cycle latency.
- `sonuc_done` stays 1.
- The sequencer may therefore settle inputs after raising `en_i`. The result is correct once the inputs have been stable for 3 edges.

When `en_i` drops:
- On the first edge with `en_i`=0, `sonuc_done` clears and the pipeline freezes.
- `data_o` holds its last value until new work arrives.

States:
- IDLE (count 0) → FILL (count 1–2) → DONE (count 3).
- `en_i`=0 from any state → IDLE.

## Timing
Reset values:
- `data_o` = 0.
- `sonuc_done` = 0.
- All pipeline registers and the counter = 0.

Reset behaviour:
- Reset has priority over `en_i`.
- Reset asserted mid-computation aborts it. `sonuc_done` is 0 on the following cycle.

Latency:
- `en_i` sampled high at edge E1 → `sonuc_done`=1 and valid `data_o` after edge E3, i.e. 3 cycles.
- Input change at edge Ek while `en_i`=1 → reflected in `data_o` after Ek+2.

Handshake:
- The consumer captures `data_o` in any cycle with `sonuc_done`=1, then lowers `en_i`.
- A new request needs at least one cycle with `en_i`=0.
- `en_i` pulses shorter than 3 cycles never raise `sonuc_done`.

Boundary behaviour:
- No internal buffering. One window is in flight at a time.
- Back-to-back requests separated by one low cycle are legal. `sonuc_done` is low for at least 3 cycles between results.

## Configuration
- `LAPLACIAN_DIAG_EN` defined → 8-neighbour kernel: L = 8·p4 − Σ(the other eight pixels).
  - Intermediate width is at least 13 bits signed.
  - Same saturation, latency, and handshake.
- `LAPLACIAN_DIAG_EN` undefined → 4-neighbour kernel as above. Corner pixels 0, 2, 6, 8 are ignored.

## Test plan
- Reset: assert `rst_i` 2 cycles with `en_i`=1 → `data_o`=0 and `sonuc_done`=0 throughout. The first done arrives 3 cycles after release.
- Flat window: all pixels = 100, `en_i` held → `sonuc_done`=1 after 3 cycles, `data_o`=0. Drop `en_i` → done=0 next cycle, `data_o` holds 0.
- Mixed window, default kernel: p4=50, p1=10, p3=20, p5=30, p7=40, corners 255 → `data_o`=+100 (0x064).
- Saturation, default kernel:
  - p4=255, others 0 → 1020 clamps to +255 (0x0FF).
  - p4=0, others 255 → −1020 clamps to −256 (0x100).
- Late-settling inputs: raise `en_i` with all pixels 0, then apply the mixed window above one cycle later and hold for 36 cycles → `data_o`=+100 when sampled at cycle 36. `sonuc_done` never drops while `en_i`=1.
- `LAPLACIAN_DIAG_EN`: p4=10, others 1 → `data_o`=72. `en_i` pulse of 2 cycles → `sonuc_done` stays 0.
